// File: rtl/chess_move_pkg.sv
// Shared move-word layout and drain FSM encodings for the move FIFO reader.
package chess_move_pkg;

   localparam int MOVE_W  = 19;
   localparam int SLOTS   = 8;
   localparam int WORD_W  = 160;
   localparam int SLOT_IW = 3;

   // Move flag bit positions; [11:6] is the from square, [5:0] the to square.
   localparam int FLAG_INVALID = 18;
   localparam int FLAG_PROMOTE = 17;
   localparam int FLAG_PAWN    = 16;
   localparam int FLAG_PAWN2   = 15;
   localparam int FLAG_EP      = 14;
   localparam int FLAG_CASTLE  = 13;
   localparam int FLAG_CAPTURE = 12;

   // Filler written into unused slots by the square units.
   localparam logic [MOVE_W-1:0] IMOV = 19'h40000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SCAN,
      ST_READ,
      ST_LATCH,
      ST_EMIT,
      ST_DONE
   } drain_state_e;

endpackage

// File: rtl/move_slot_picker.sv
// Combinational pick of the highest-numbered pending slot of a FIFO word.
module move_slot_picker
   import chess_move_pkg::*;
(
   input  logic [SLOTS-1:0]        mask,
   input  logic [SLOTS*MOVE_W-1:0] slots,
   output logic [SLOT_IW-1:0]      slot_idx,
   output logic [MOVE_W-1:0]       move,
   output logic                    any_set
);

   // Ascending scan so the last (highest) set bit wins.
   always_comb begin
      slot_idx = '0;
      any_set  = 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
         if (mask[k]) begin
            slot_idx = SLOT_IW'(k);
            any_set  = 1'b1;
         end
      end
      move = slots[slot_idx*MOVE_W +: MOVE_W];
   end

endmodule

// File: rtl/move_fifo_drain.sv
// Reader side of the per-square move FIFOs: waits for all squares done, drains
// each FIFO in square order and streams valid moves over a valid/ready port.
// Optional build macro CAPTURE_COUNT_EN adds the capt_count port and counter.
//
// state | meaning
// IDLE  | waiting for start after reset
// WAIT  | pass armed, waiting for every square to report done
// SCAN  | test empty flag of square idx, one square per cycle
// READ  | one-cycle read pulse to FIFO idx
// LATCH | capture popped word and its valid-slot mask
// EMIT  | present pending slots highest first, one per handshake
// DONE  | pass complete, done held until next start
module move_fifo_drain
   import chess_move_pkg::*;
#(
   parameter int NSQ = 64,
   parameter int MCW = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NSQ-1:0]          sq_done,
   input  logic [NSQ-1:0]          sq_empty,
   input  logic [NSQ*WORD_W-1:0]   sq_data,
   output logic [NSQ-1:0]          sq_rden,
   output logic                    mv_valid,
   output logic [MOVE_W-1:0]       mv_data,
   input  logic                    mv_ready,
   output logic                    done,
   output logic [MCW-1:0]          move_count
`ifdef CAPTURE_COUNT_EN
   ,
   output logic [MCW-1:0]          capt_count
`endif
);

   localparam int IW = (NSQ > 1) ? $clog2(NSQ) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NSQ - 1);

   drain_state_e            state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [SLOTS*MOVE_W-1:0] word_q, word_d;
   logic [SLOTS-1:0]        mask_q, mask_d;
   logic [SLOT_IW-1:0]      cur_q, cur_d;
   logic [NSQ-1:0]          sq_rden_q, sq_rden_d;
   logic                    mv_valid_q, mv_valid_d;
   logic [MOVE_W-1:0]       mv_data_q, mv_data_d;
   logic                    done_q, done_d;
   logic [MCW-1:0]          move_count_q, move_count_d;
   logic [MCW-1:0]          capt_count_q, capt_count_d;

   logic [WORD_W-1:0]       sel_word;
   logic [SLOTS-1:0]        latch_mask;
   logic [SLOTS-1:0]        pick_mask;
   logic [SLOTS*MOVE_W-1:0] pick_slots;
   logic [SLOT_IW-1:0]      pick_idx;
   logic [MOVE_W-1:0]       pick_move;
   logic                    pick_any;
   logic                    xfer;
   logic                    unused_pad;

   function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   assign sel_word   = sq_data[idx_q*WORD_W +: WORD_W];
   assign unused_pad = ^sel_word[WORD_W-1:SLOTS*MOVE_W];
   assign xfer       = mv_valid_q & mv_ready;

   // Valid-slot mask of the word on the FIFO q bus.
   always_comb begin
      latch_mask = '0;
      for (int k = 0; k < SLOTS; k++)
         latch_mask[k] = ~sel_word[k*MOVE_W + FLAG_INVALID];
   end

   // The picker looks ahead: in LATCH at the fresh word, in EMIT at what remains after the current slot.
   assign pick_mask  = (state_q == ST_LATCH) ? latch_mask
                                             : (mask_q & ~(SLOTS'(1) << cur_q));
   assign pick_slots = (state_q == ST_LATCH) ? sel_word[SLOTS*MOVE_W-1:0] : word_q;

   move_slot_picker u_picker (
      .mask     (pick_mask),
      .slots    (pick_slots),
      .slot_idx (pick_idx),
      .move     (pick_move),
      .any_set  (pick_any)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      word_d       = word_q;
      mask_d       = mask_q;
      cur_d        = cur_q;
      sq_rden_d    = '0;
      mv_valid_d   = mv_valid_q;
      mv_data_d    = mv_data_q;
      done_d       = done_q;
      move_count_d = move_count_q;
      capt_count_d = capt_count_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_WAIT;
               done_d       = 1'b0;
               move_count_d = '0;
               capt_count_d = '0;
            end
         end
         ST_WAIT: begin
            if (&sq_done) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end
         end
         ST_SCAN: begin
            if (!sq_empty[idx_q]) begin
               state_d   = ST_READ;
               sq_rden_d = NSQ'(1) << idx_q;
            end else if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_READ: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            word_d = sel_word[SLOTS*MOVE_W-1:0];
            mask_d = latch_mask;
            if (pick_any) begin
               state_d    = ST_EMIT;
               mv_valid_d = 1'b1;
               mv_data_d  = pick_move;
               cur_d      = pick_idx;
            end else begin
               state_d = ST_SCAN;
            end
         end
         ST_EMIT: begin
            if (xfer) begin
               move_count_d = sat_inc(move_count_q);
               if (mv_data_q[FLAG_CAPTURE])
                  capt_count_d = sat_inc(capt_count_q);
               mask_d = pick_mask;
               if (pick_any) begin
                  mv_data_d = pick_move;
                  cur_d     = pick_idx;
               end else begin
                  state_d    = ST_SCAN;
                  mv_valid_d = 1'b0;
                  mv_data_d  = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         word_q       <= '0;
         mask_q       <= '0;
         cur_q        <= '0;
         sq_rden_q    <= '0;
         mv_valid_q   <= 1'b0;
         mv_data_q    <= '0;
         done_q       <= 1'b0;
         move_count_q <= '0;
         capt_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         mask_q       <= mask_d;
         cur_q        <= cur_d;
         sq_rden_q    <= sq_rden_d;
         mv_valid_q   <= mv_valid_d;
         mv_data_q    <= mv_data_d;
         done_q       <= done_d;
         move_count_q <= move_count_d;
         capt_count_q <= capt_count_d;
      end
   end

   assign sq_rden    = sq_rden_q;
   assign mv_valid   = mv_valid_q;
   assign mv_data    = mv_data_q;
   assign done       = done_q;
   assign move_count = move_count_q;

`ifdef CAPTURE_COUNT_EN
   assign capt_count = capt_count_q;
`else
   logic unused_capt;
   assign unused_capt = ^capt_count_q;
`endif

endmodule

// File: tb/tb_move_fifo_drain.sv
// Bench for move_fifo_drain: FIFO queues and consumer live in the bench; the
// expected move stream is derived straight from the FIFO contents.
module tb_move_fifo_drain;
   import chess_move_pkg::*;

   localparam int NSQ = 64;
   localparam int MCW = 8;
   localparam int BUDGET = 20000;

   logic                  clk = 1'b0;
   logic                  reset, start, mv_ready;
   logic [NSQ-1:0]        sq_done, sq_empty, sq_rden;
   logic [NSQ*WORD_W-1:0] sq_data;
   logic                  mv_valid, done;
   logic [MOVE_W-1:0]     mv_data;
   logic [MCW-1:0]        move_count;
`ifdef CAPTURE_COUNT_EN
   logic [MCW-1:0]        capt_count;
`endif

   move_fifo_drain #(.NSQ(NSQ), .MCW(MCW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .sq_done    (sq_done),
      .sq_empty   (sq_empty),
      .sq_data    (sq_data),
      .sq_rden    (sq_rden),
      .mv_valid   (mv_valid),
      .mv_data    (mv_data),
      .mv_ready   (mv_ready),
      .done       (done),
      .move_count (move_count)
`ifdef CAPTURE_COUNT_EN
      ,
      .capt_count (capt_count)
`endif
   );

   always #5 clk = ~clk;

   logic [WORD_W-1:0] fq [NSQ][$];
   logic [MOVE_W-1:0] expq[$];
   logic [MOVE_W-1:0] gotq[$];
   int                exp_pops[$];
   int                got_pops[$];
   int                vectors = 0;
   int                miscompares = 0;
   int                cycles, stall_left, ready_pct;
   bit                glitch_en, glitched;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: record handshake/pops, model FIFOs, drive consumer, check protocol.
   task automatic tick();
      logic [NSQ-1:0]    r;
      logic              hold, rs;
      logic [MOVE_W-1:0] d;
      r    = sq_rden;
      rs   = reset;
      d    = mv_data;
      hold = mv_valid & ~mv_ready;
      if (!rs && (mv_valid & mv_ready) === 1'b1) gotq.push_back(mv_data);
      @(posedge clk);
      #1;
      cycles++;
      start = 1'b0;
      if (r != '0) begin
         chk("rden_onehot", 64'($onehot(r)), 1);
         chk("rden_single_pulse", 64'(sq_rden), 0);
         for (int i = 0; i < NSQ; i++) begin
            if (r[i]) begin
               chk("pop_nonempty", 64'(fq[i].size() > 0), 1);
               got_pops.push_back(i);
               if (fq[i].size() > 0) sq_data[i*WORD_W +: WORD_W] = fq[i].pop_front();
            end
         end
      end
      for (int i = 0; i < NSQ; i++) sq_empty[i] = (fq[i].size() == 0);
      if (!rs && !reset && hold === 1'b1)
         chk("hold_stable", {44'd0, mv_valid, mv_data}, {44'd0, 1'b1, d});
      if (mv_valid === 1'b1) chk("invalid_bit_clear", 64'(mv_data[FLAG_INVALID]), 0);
      if (stall_left > 0 && mv_valid === 1'b1) begin
         mv_ready = 1'b0;
         stall_left--;
      end else begin
         mv_ready = ($urandom_range(99) < ready_pct);
      end
      if (glitch_en && !glitched && gotq.size() >= 2) begin
         start    = 1'b1;
         glitched = 1'b1;
      end
   endtask

   function automatic logic [WORD_W-1:0] rand_word(input logic [SLOTS-1:0] vmask);
      logic [WORD_W-1:0] w;
      logic [MOVE_W-1:0] mv;
      w = '0;
      for (int k = 0; k < SLOTS; k++) begin
         mv = MOVE_W'($urandom);
         mv[FLAG_INVALID] = ~vmask[k];
         w[k*MOVE_W +: MOVE_W] = mv;
      end
      return w;
   endfunction

   task automatic push_word(input int sq, input logic [WORD_W-1:0] w);
      fq[sq].push_back(w);
      sq_empty[sq] = 1'b0;
   endtask

   // Reference: squares in order, words in FIFO order, valid slots 7 down to 0.
   task automatic build_expect();
      logic [WORD_W-1:0] w;
      expq.delete();
      exp_pops.delete();
      for (int s = 0; s < NSQ; s++) begin
         for (int j = 0; j < fq[s].size(); j++) begin
            w = fq[s][j];
            exp_pops.push_back(s);
            for (int k = SLOTS - 1; k >= 0; k--)
               if (!w[k*MOVE_W + FLAG_INVALID]) expq.push_back(w[k*MOVE_W +: MOVE_W]);
         end
      end
   endtask

   task automatic begin_pass(input int pct, input int stall, input bit glitch);
      build_expect();
      gotq.delete();
      got_pops.delete();
      ready_pct  = pct;
      stall_left = stall;
      glitch_en  = glitch;
      glitched   = 1'b0;
      cycles     = 0;
      start      = 1'b1;
      tick();
   endtask

   task automatic finish_pass();
      int n, ncap;
      while (done !== 1'b1 && cycles < BUDGET) tick();
      chk("pass_done_in_budget", 64'(done), 1);
      chk("move_total", 64'(gotq.size()), 64'(expq.size()));
      n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
      for (int i = 0; i < n; i++) chk("move_data", 64'(gotq[i]), 64'(expq[i]));
      chk("pop_total", 64'(got_pops.size()), 64'(exp_pops.size()));
      n = (got_pops.size() < exp_pops.size()) ? got_pops.size() : exp_pops.size();
      for (int i = 0; i < n; i++) chk("pop_square", 64'(got_pops[i]), 64'(exp_pops[i]));
      chk("move_count", 64'(move_count), (expq.size() > 255) ? 255 : 64'(expq.size()));
      ncap = 0;
      foreach (expq[i]) if (expq[i][FLAG_CAPTURE]) ncap++;
`ifdef CAPTURE_COUNT_EN
      chk("capt_count", 64'(capt_count), (ncap > 255) ? 255 : 64'(ncap));
`endif
      chk("mv_valid_after_pass", 64'(mv_valid), 0);
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < NSQ; i++) fq[i].delete();
      sq_empty = '1;
   endtask

   initial begin
      logic [WORD_W-1:0] w;
      logic [MOVE_W-1:0] mv;
      int                guard;
      int                nw;

      reset = 1'b1; start = 1'b0; mv_ready = 1'b0; sq_done = '0;
      sq_empty = '1; sq_data = '0; ready_pct = 0; stall_left = 0;
      glitch_en = 1'b0; glitched = 1'b0; cycles = 0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_mv_valid", 64'(mv_valid), 0);
      chk("rst_mv_data", 64'(mv_data), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_move_count", 64'(move_count), 0);
      chk("rst_rden", 64'(sq_rden != '0), 0);

      // 1: all empty
      sq_done = '1;
      begin_pass(100, 0, 1'b0);
      finish_pass();
      chk("t1_done_latency", 64'(cycles), 64'(NSQ + 2));
      tick(); tick(); tick();
      chk("t1_done_held", 64'(done), 1);

      // 2: square 9 slots 7 and 2, with a WAIT phase first
      w = '0;
      for (int k = 0; k < SLOTS; k++) w[k*MOVE_W +: MOVE_W] = IMOV;
      w[7*MOVE_W +: MOVE_W] = 19'h00A1C;
      w[2*MOVE_W +: MOVE_W] = 19'h0108F;
      push_word(9, w);
      sq_done = '1;
      sq_done[5] = 1'b0;
      begin_pass(100, 0, 1'b0);
      repeat (10) tick();
      chk("t2_wait_no_pop", 64'(got_pops.size()), 0);
      chk("t2_wait_no_move", 64'(mv_valid), 0);
      chk("t2_wait_done_low", 64'(done), 0);
      sq_done = '1;
      finish_pass();

      // 3: same word, consumer stalls 5 cycles
      push_word(9, w);
      begin_pass(100, 5, 1'b0);
      finish_pass();
      chk("t3_stall_consumed", 64'(stall_left), 0);

      // 4: multi-word square 0, then square 1, then an all-invalid word
      push_word(0, rand_word(8'hA5));
      push_word(0, rand_word(8'h3C));
      push_word(1, rand_word(8'h81));
      push_word(2, rand_word(8'h00));
      begin_pass(70, 0, 1'b0);
      finish_pass();

      // 5: reset in the middle of EMIT
      push_word(3, rand_word(8'hFF));
      begin_pass(100, 0, 1'b0);
      guard = 0;
      while (!(gotq.size() >= 3 && mv_valid === 1'b1) && guard < 500) begin
         tick();
         guard++;
      end
      chk("t5_reached_emit", 64'(guard < 500), 1);
      chk("t5_count_before_reset", 64'(move_count), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_mv_valid", 64'(mv_valid), 0);
      chk("t5_mv_data", 64'(mv_data), 0);
      chk("t5_rden", 64'(sq_rden != '0), 0);
      chk("t5_done", 64'(done), 0);
      chk("t5_move_count", 64'(move_count), 0);
      repeat (5) tick();
      chk("t5_idle_no_move", 64'(mv_valid), 0);
      chk("t5_idle_no_done", 64'(done), 0);
      clear_fifos();

      // 6: 3 captures + 2 quiet moves, with a start pulse mid-pass
      w = '0;
      for (int k = 0; k < SLOTS; k++) begin
         mv = MOVE_W'($urandom);
         mv[FLAG_INVALID] = (k > 4);
         mv[FLAG_CAPTURE] = (k < 3);
         w[k*MOVE_W +: MOVE_W] = mv;
      end
      push_word(20, w);
      begin_pass(60, 0, 1'b1);
      finish_pass();
      chk("t6_glitch_seen", 64'(glitched), 1);

      // random passes, last one overflows the 8-bit counters
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < NSQ; s++) begin
            nw = ($urandom_range(3) == 0) ? $urandom_range(3) : 0;
            for (int j = 0; j < nw; j++) push_word(s, rand_word(SLOTS'($urandom)));
         end
         begin_pass($urandom_range(100, 30), $urandom_range(4), 1'b0);
         finish_pass();
      end
      for (int s = 0; s < NSQ; s++) push_word(s, rand_word(8'hFF));
      begin_pass(100, 0, 1'b0);
      finish_pass();
      chk("sat_move_count", 64'(move_count), 255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
